// File: rtl/alu_op_scheduler_if.sv
`timescale 1ns/1ps
// Shared-ALU scheduler bundle: two requesters, ALU operand/result side, response channel.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both request ports and on the response port.
//
// The master modport is the environment (requesters, consumer, ALU instance).
// The slave modport is the scheduler itself.
interface alu_op_scheduler_if #(
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [3:0]    req0_sel;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [3:0]    req1_sel;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_sel;
    logic [DW-1:0] alu_res;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_id;
    logic          busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_res,
        input  rsp_valid, rsp_data, rsp_id, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_res,
        output rsp_valid, rsp_data, rsp_id, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_op_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Latency: accept at N -> rsp_valid at N+cycles(sel)+1 (cycles: mul=MUL_CYC, div=DIV_CYC, else 1).
// Backpressure: rsp_ready low holds DONE; no request is accepted until the response leaves.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries both
// request ports, the ALU operand/result side, the response channel and busy.
// Optional macro ALU_OP_SCHEDULER_FWD_EN: arbitrate in DONE while rsp_ready is
// high so a new op can enter EXEC in the same cycle the response is taken.
module alu_op_scheduler #(
    parameter int DW      = 32,
    parameter int MUL_CYC = 4,
    parameter int DIV_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_scheduler_if.slave   bus
);
    localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYC - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;      // requester granted most recently
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_sel;
    logic          r_id;
    logic [DW-1:0] r_data;
    logic          r_rsp_valid;
    logic          r_busy;

    logic          w_gnt_any;
    logic          w_gnt_id;
    logic          w_arb_en;
    logic          w_accept;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [3:0]    w_sel;
    logic [CW-1:0] w_ld_cnt;

    always_comb begin
        w_gnt_any = bus.req0_valid | bus.req1_valid;
        // On a tie the requester not served last wins; otherwise whoever is valid.
        w_gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
`ifdef ALU_OP_SCHEDULER_FWD_EN
        w_arb_en  = ~rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.rsp_ready));
`else
        w_arb_en  = ~rst & (r_state == S_IDLE);
`endif
        w_accept  = w_arb_en & w_gnt_any;
        w_a       = w_gnt_id ? bus.req1_a   : bus.req0_a;
        w_b       = w_gnt_id ? bus.req1_b   : bus.req0_b;
        w_sel     = w_gnt_id ? bus.req1_sel : bus.req0_sel;
        // Counter holds remaining EXEC cycles minus one.
        case (w_sel)
            4'd2:    w_ld_cnt = MUL_LD;
            4'd3:    w_ld_cnt = DIV_LD;
            default: w_ld_cnt = '0;
        endcase
    end

    assign bus.req0_ready = w_accept & ~w_gnt_id;
    assign bus.req1_ready = w_accept &  w_gnt_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_id        <= 1'b0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Also covers the forwarded case: the pending response completes here.
            r_a         <= w_a;
            r_b         <= w_b;
            r_sel       <= w_sel;
            r_id        <= w_gnt_id;
            r_last      <= w_gnt_id;
            r_cnt       <= w_ld_cnt;
            r_state     <= S_EXEC;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_data      <= bus.alu_res;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ALU inputs come straight from the latches so they never toggle outside EXEC.
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_sel   = r_sel;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_data;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_op_scheduler.sv
`timescale 1ns/1ps
// Directed bench for alu_op_scheduler with a behavioural ALU on the shared port.
// Inputs are driven on the falling edge, outputs sampled 1ns later.
// Cycle references count falling edges from the cycle in which ready is seen high.
module tb_alu_op_scheduler;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.DW(DW)) bus();

    alu_op_scheduler #(.DW(DW), .MUL_CYC(4), .DIV_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return a + 32'd1;
            4'd10:   return a - 32'd1;
            4'd11:   return 32'($countones(a ^ b));
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_res = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] sel);
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
        end
    endtask

    // Returns 1ns after the falling edge of the cycle in which ready is high.
    task automatic wait_accept(input string tag, input bit id);
        int n = 0;
        #1;
        while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, " accept"}, 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
    endtask

    // Drops both valids after the accept edge and counts cycles up to rsp_valid.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
            lat++;
        end while (!bus.rsp_valid && lat < exp_lat + 10);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1, acc2, rsp1c, rsp2c, exp_acc;
        logic [31:0] d1, d2, exp_d;
        logic [31:0] gq[$];
        logic [31:0] rq_id[$];
        logic [31:0] rq_dat[$];

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state, with both valids raised during the reset cycle.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check_eq("rst req0_ready", 32'(bus.req0_ready), 32'd0);
        check_eq("rst req1_ready", 32'(bus.req1_ready), 32'd0);
        check_eq("rst rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check_eq("rst busy",       32'(bus.busy),       32'd0);
        check_eq("rst alu_a",      bus.alu_a,           32'd0);
        check_eq("rst alu_b",      bus.alu_b,           32'd0);
        check_eq("rst alu_sel",    32'(bus.alu_sel),    32'd0);
        check_eq("rst rsp_data",   bus.rsp_data,        32'd0);
        check_eq("rst rsp_id",     32'(bus.rsp_id),     32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Single add from req0: 5+3.
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(0, 32'd5, 32'd3, 4'd0);
        wait_accept("add", 0);
        check_eq("add req1_ready", 32'(bus.req1_ready), 32'd0);
        wait_rsp("add", 2);
        check_eq("add rsp_data", bus.rsp_data, 32'd8);
        check_eq("add rsp_id",   32'(bus.rsp_id), 32'd0);
        @(negedge clk); #1;
        check_eq("add rsp_valid drop", 32'(bus.rsp_valid), 32'd0);
        check_eq("add busy drop",      32'(bus.busy),      32'd0);

        // Mul from req1: 7*6 over 4 EXEC cycles with stable ALU inputs.
        @(negedge clk);
        drive_req(1, 32'd7, 32'd6, 4'd2);
        wait_accept("mul", 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.req1_valid = 1'b0;
            #1;
            check_eq("mul alu_a",     bus.alu_a,          32'd7);
            check_eq("mul alu_b",     bus.alu_b,          32'd6);
            check_eq("mul alu_sel",   32'(bus.alu_sel),   32'd2);
            check_eq("mul early rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk); #1;
        check_eq("mul rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("mul rsp_data",  bus.rsp_data,       32'd42);
        check_eq("mul rsp_id",    32'(bus.rsp_id),    32'd1);

        // Contention from reset: both valid with xor b=0, operands bumped per accept.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k0 = 0; k1 = 0;
        drive_req(0, 32'h100, 32'd0, 4'd6);
        drive_req(1, 32'h200, 32'd0, 4'd6);
        for (int c = 0; c < 24; c++) begin
            #1;
            if (bus.req0_ready) begin gq.push_back(32'd0); k0++; end
            if (bus.req1_ready) begin gq.push_back(32'd1); k1++; end
            if (bus.rsp_valid) begin
                rq_id.push_back(32'(bus.rsp_id));
                rq_dat.push_back(bus.rsp_data);
            end
            @(negedge clk);
            bus.req0_a = 32'h100 + 32'(k0);
            bus.req1_a = 32'h200 + 32'(k1);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_eq("cont drained", 32'(bus.busy), 32'd0);
        check_eq("cont grants>=6", 32'(gq.size() >= 6), 32'd1);
        check_eq("cont rsps>=6",   32'(rq_id.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            exp_d = ((i % 2) != 0) ? 32'h200 + 32'(i / 2) : 32'h100 + 32'(i / 2);
            check_eq("cont grant", (i < gq.size())     ? gq[i]     : 32'hDEAD, 32'(i % 2));
            check_eq("cont rsp_id", (i < rq_id.size()) ? rq_id[i]  : 32'hDEAD, 32'(i % 2));
            check_eq("cont rsp_dat", (i < rq_dat.size()) ? rq_dat[i] : 32'hDEAD, exp_d);
        end

        // Back-pressure: div 100/7 held in DONE for 10 cycles with both requesters waiting.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive_req(0, 32'd100, 32'd7, 4'd3);
        wait_accept("div", 0);
        wait_rsp("div", 9);
        check_eq("div rsp_data", bus.rsp_data, 32'd14);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_req(0, 32'd1, 32'd1, 4'd0);
            drive_req(1, 32'd2, 32'd2, 4'd0);
            #1;
            check_eq("bp rsp_valid",  32'(bus.rsp_valid),  32'd1);
            check_eq("bp rsp_data",   bus.rsp_data,        32'd14);
            check_eq("bp rsp_id",     32'(bus.rsp_id),     32'd0);
            check_eq("bp req0_ready", 32'(bus.req0_ready), 32'd0);
            check_eq("bp req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        check_eq("bp release valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk); #1;
        check_eq("bp idle busy",  32'(bus.busy),      32'd0);
        check_eq("bp idle valid", 32'(bus.rsp_valid), 32'd0);

        // Reset during the 3rd EXEC cycle of a div, then a fresh add.
        @(negedge clk);
        drive_req(0, 32'd50, 32'd5, 4'd3);
        wait_accept("rdiv", 0);
        @(negedge clk); bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rdiv busy before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rdiv rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rdiv busy",      32'(bus.busy),      32'd0);
        check_eq("rdiv alu_a",     bus.alu_a,          32'd0);
        check_eq("rdiv alu_b",     bus.alu_b,          32'd0);
        check_eq("rdiv alu_sel",   32'(bus.alu_sel),   32'd0);
        @(negedge clk);
        drive_req(0, 32'd9, 32'd1, 4'd0);
        wait_accept("post", 0);
        wait_rsp("post", 2);
        check_eq("post rsp_data", bus.rsp_data,    32'd10);
        check_eq("post rsp_id",   32'(bus.rsp_id), 32'd0);

        // Back-to-back adds from req0: forwarding removes the idle cycle.
        @(negedge clk);
        drive_req(0, 32'd1, 32'd2, 4'd0);
        wait_accept("b2b", 0);
        acc2 = -1; rsp1c = -1; rsp2c = -1; d1 = '0; d2 = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.req0_a = 32'd10; bus.req0_b = 32'd20; end
            if (acc2 >= 0) bus.req0_valid = 1'b0;
            #1;
            if (bus.rsp_valid && rsp1c < 0) begin
                rsp1c = c; d1 = bus.rsp_data;
            end else if (bus.rsp_valid && rsp1c >= 0 && rsp2c < 0 && c > rsp1c) begin
                rsp2c = c; d2 = bus.rsp_data;
            end
            if (bus.req0_ready && acc2 < 0) acc2 = c;
        end
`ifdef ALU_OP_SCHEDULER_FWD_EN
        exp_acc = 2;
`else
        exp_acc = 3;
`endif
        check_eq("b2b rsp1 cycle",   32'(rsp1c), 32'd2);
        check_eq("b2b rsp1 data",    d1,         32'd3);
        check_eq("b2b accept2 cycle", 32'(acc2), 32'(exp_acc));
        check_eq("b2b rsp2 cycle",   32'(rsp2c), 32'(exp_acc + 2));
        check_eq("b2b rsp2 data",    d2,         32'd30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Two-requester scheduler that shares one 32-bit ALU (add/sub, mul, div, logic, shift, inc/dec, Hamming) between independent operation sources. It arbitrates round-robin, latches operands and select code, holds them on the ALU inputs for the op's fixed latency, then returns the captured result on a valid/ready response channel. It sits between the core's issue stage and the shared ALU instance.

## Interface
Parameters:
- `DW`, 32, operand/result width
- `MUL_CYC`, 4, EXEC cycles for sel=4'd2 (mul), min 1
- `DIV_CYC`, 8, EXEC cycles for sel=4'd3 (div), min 1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an op
- `req0_ready`  out  1  requester 0 op accepted this cycle
- `req0_a`, `req0_b`  in  DW  operands
- `req0_sel`  in  4  ALU select code
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same for requester 1
- `alu_a`, `alu_b`  out  DW  to shared ALU
- `alu_sel`  out  4  to shared ALU
- `alu_res`  in  DW  from shared ALU (combinational)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_data`  out  DW  result
- `rsp_id`  out  1  requester that issued the op
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: grant = requester with valid; if both valid, the one not granted last (pointer `last`). Only the granted requester sees ready=1; ready never asserted outside IDLE (except see Configuration). On handshake: latch a, b, sel, id; load counter = cycles(sel)-1; update `last`; go EXEC.
- cycles(sel): 2 -> MUL_CYC, 3 -> DIV_CYC, all others -> 1.
- EXEC: alu_a/alu_b/alu_sel driven from latches, stable throughout. Counter decrements each cycle; at counter==0 capture alu_res into rsp_data, go DONE.
- DONE: rsp_valid=1; rsp_data, rsp_id stable until rsp_valid&rsp_ready; then IDLE.
- ALU outputs hold last latched values in IDLE/DONE (no toggling).
- Result is passed through unmodified (div-by-zero, overflow handled by ALU; no error flag).
- rsp_ready ignored outside DONE; req valids ignored outside grant cycles; a requester that drops valid before ready loses nothing.

## Timing
- Reset: state=IDLE, `last`=1 (req0 wins first tie), rsp_valid=0, rsp_data=0, rsp_id=0, alu_a=alu_b=0, alu_sel=0, busy=0, counter=0, both readys=0 during the reset cycle.
- Accept at cycle N -> EXEC cycles N+1..N+k (k=cycles(sel)) -> rsp_valid first high at N+k+1.
- Single-cycle op: rsp_valid at N+2; with rsp_ready held high, next accept at N+3 (N+2 with FWD).
- Reset asserted in EXEC or DONE: op and pending response discarded, all outputs to reset values next edge.
- Simultaneous valids on every IDLE: grants strictly alternate 0,1,0,1.
- Back-pressure: rsp_ready low holds DONE indefinitely; no new accepts.

## Configuration
- `ALU_OP_SCHEDULER_FWD_EN` defined: in DONE with rsp_ready=1, arbitration runs and the granted requester's ready is asserted; a handshake there completes the response and enters EXEC directly (zero bubble). Same round-robin rules.
- Undefined: DONE always returns to IDLE; one idle cycle between response handshake and next accept.

## Test plan
- Single add: req0 a=5 b=3 sel=add, rsp_ready=1 -> rsp_valid at accept+2, rsp_data=8, rsp_id=0.
- Mul latency: req1 a=7 b=6 sel=2, MUL_CYC=4 -> alu_* stable 4 cycles, rsp_valid at accept+5, rsp_data=42, rsp_id=1.
- Contention: both valid continuously, sel=xor -> grants 0,1,0,1 from reset; rsp_id alternates; no op lost or duplicated.
- Back-pressure: rsp_ready=0 for 10 cycles after div 100/7 -> rsp_valid held, rsp_data=14 stable, both readys=0; release -> IDLE next cycle.
- Reset mid-div: rst=1 at 3rd EXEC cycle -> next edge rsp_valid=0, busy=0, alu_*=0; fresh req0 after reset completes normally.
- FWD: with macro, two req0 adds back-to-back, rsp_ready=1 -> second accept in the same cycle as first response handshake; without macro, one-cycle gap.
